// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and default masks for the truth-table response checker
package tt_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } tt_state_t;

    localparam logic [7:0] TT_F_MASK  = 8'h37;
    localparam logic [7:0] TT_F1_MASK = 8'hC8;
    localparam int         TT_CNT_W   = 8;
endpackage

// File: rtl/tt_lane.sv
// rtl/tt_lane.sv - one function lane: observed truth table, first-capture/conflict compare, error slice
module tt_lane
    import tt_pkg::*;
#(
    parameter int                    N_IN = 3,
    parameter logic [(1<<N_IN)-1:0]  EXP  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  first,
    input  logic [N_IN-1:0]       idx,
    input  logic                  val,
    input  logic [(1<<N_IN)-1:0]  seen_mask,
    output logic [(1<<N_IN)-1:0]  obs,
    output logic [(1<<N_IN)-1:0]  err,
    output logic                  mismatch
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs <= '0;
        end else if (clear) begin
            obs <= '0;
        end else if (accept && first) begin
            obs[idx] <= val;
        end
    end

    // A repeat keeps the first captured value; only the disagreement is reported.
    assign mismatch = accept && !first && (obs[idx] != val);
    assign err      = (obs ^ EXP) & seen_mask;
endmodule

// File: rtl/tt_response_checker.sv
// rtl/tt_response_checker.sv - rebuilds observed truth tables and checks them; TT_TIMEOUT_EN adds a watchdog
module tt_response_checker
    import tt_pkg::*;
#(
    parameter int                                N_IN        = 3,
    parameter int                                N_FUNC      = 2,
    parameter logic [N_FUNC*(1<<N_IN)-1:0]       EXP_MASK    = {TT_F1_MASK, TT_F_MASK},
    parameter int                                TIMEOUT_CYC = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_IN-1:0]                  in_vec,
    input  logic [N_FUNC-1:0]                out_vec,
    output logic                             done,
    output logic                             pass,
    output logic                             conflict,
    output logic                             timeout,
    output logic [(1<<N_IN)-1:0]             seen_mask,
    output logic [N_FUNC*(1<<N_IN)-1:0]      obs_mask,
    output logic [N_FUNC*(1<<N_IN)-1:0]      err_mask,
    output logic [TT_CNT_W-1:0]              sample_cnt
);
    localparam int DEPTH = 1 << N_IN;

    tt_state_t         state, state_next;
    logic              accept, new_acc, all_seen, fin, wd_hit;
    logic [N_FUNC-1:0] mis;

    assign in_ready = (state == CAPTURE);
    assign accept   = in_valid && in_ready && !start;
    assign new_acc  = accept && !seen_mask[in_vec];
    assign all_seen = &seen_mask;
    assign fin      = (state == CAPTURE) && !start && all_seen;

    for (genvar k = 0; k < N_FUNC; k++) begin : g_lane
        tt_lane #(
            .N_IN (N_IN),
            .EXP  (EXP_MASK[k*DEPTH +: DEPTH])
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (start),
            .accept    (accept),
            .first     (!seen_mask[in_vec]),
            .idx       (in_vec),
            .val       (out_vec[k]),
            .seen_mask (seen_mask),
            .obs       (obs_mask[k*DEPTH +: DEPTH]),
            .err       (err_mask[k*DEPTH +: DEPTH]),
            .mismatch  (mis[k])
        );
    end

`ifdef TT_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // A new minterm on the expiry cycle wins and the run continues.
    assign wd_hit = (state == CAPTURE) && !start && !new_acc && !all_seen
                    && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (start) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (state == CAPTURE) begin
            if (new_acc) begin
                wd_cnt <= '0;
            end else if (wd_hit) begin
                timeout_q <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
    assign timeout = timeout_q;
`else
    assign wd_hit  = 1'b0 & (TIMEOUT_CYC != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CAPTURE;
            CAPTURE: begin
                if (start)                   state_next = CAPTURE;
                else if (all_seen || wd_hit) state_next = DONE;
            end
            DONE:    if (start) state_next = CAPTURE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_mask  <= '0;
            sample_cnt <= '0;
            conflict   <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (start) begin
            seen_mask  <= '0;
            sample_cnt <= '0;
            conflict   <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            if (new_acc) seen_mask[in_vec] <= 1'b1;
            if (accept && (sample_cnt != '1)) sample_cnt <= sample_cnt + 1'b1;
            if (|mis) conflict <= 1'b1;
            // A conflicting repeat on the completion cycle still fails the run.
            if (fin) begin
                done <= 1'b1;
                pass <= (obs_mask == EXP_MASK) && !conflict && !(|mis) && !timeout;
            end else if (wd_hit) begin
                done <= 1'b1;
                pass <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tt_response_checker.sv
// tb/tb_tt_response_checker.sv - scoreboard bench for tt_response_checker
module tb_tt_response_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_vec;
    logic [1:0]  out_vec;
    logic        done, pass, conflict, timeout;
    logic [7:0]  seen_mask;
    logic [15:0] obs_mask, err_mask;
    logic [7:0]  sample_cnt;

    typedef struct {
        string       name;
        logic        pass;
        logic        conflict;
        logic        timeout;
        logic [7:0]  seen;
        logic [15:0] obs;
        logic [15:0] err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    logic done_d = 1'b0;

    tt_response_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_vec    (out_vec),
        .done       (done),
        .pass       (pass),
        .conflict   (conflict),
        .timeout    (timeout),
        .seen_mask  (seen_mask),
        .obs_mask   (obs_mask),
        .err_mask   (err_mask),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input string name, input logic p, input logic c, input logic t,
                        input logic [7:0] s, input logic [15:0] o, input logic [15:0] er,
                        input logic [7:0] n);
        exp_t x;
        x.name = name; x.pass = p; x.conflict = c; x.timeout = t;
        x.seen = s; x.obs = o; x.err = er; x.cnt = n;
        sb.push_back(x);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int idx, input logic f, input logic f1);
        in_valid = 1'b1;
        in_vec   = idx[2:0];
        out_vec  = {f1, f};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sweep(input logic [7:0] fm, input logic [7:0] f1m);
        for (int i = 0; i < 8; i++) send(i, fm[i], f1m[i]);
    endtask

    // Monitor: each rising done is one finished run, compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done && !done_d) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_pass"},     pass,       e.pass);
                chk({e.name, "_conflict"}, conflict,   e.conflict);
                chk({e.name, "_timeout"},  timeout,    e.timeout);
                chk({e.name, "_seen"},     seen_mask,  e.seen);
                chk({e.name, "_obs"},      obs_mask,   e.obs);
                chk({e.name, "_err"},      err_mask,   e.err);
                chk({e.name, "_cnt"},      sample_cnt, e.cnt);
            end
        end
        done_d = done;
    end

    initial begin
        logic [7:0] fm, f1m;
        fm = 8'h37; f1m = 8'hC8;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = '0; out_vec = '0;
        #1;
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_seen", seen_mask, 0);
        chk("reset_obs", obs_mask, 0);
        chk("reset_cnt", sample_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // full correct sweep
        do_start();
        push("sweep", 1, 0, 0, 8'hFF, 16'hC837, 16'h0000, 8'd8);
        sweep(fm, f1m);
        chk("done_early", done, 0);
        @(posedge clk); #1;
        chk("done_latency", done, 1);
        chk("ready_in_done", in_ready, 0);
        send(3, 1'b1, 1'b0);
        chk("ignored_cnt", sample_cnt, 8);
        chk("ignored_obs", obs_mask, 16'hC837);

        // wrong function at minterm 3
        do_start();
        push("wrong", 0, 0, 0, 8'hFF, 16'hC83F, 16'h0008, 8'd8);
        sweep(8'h3F, f1m);
        repeat (3) @(posedge clk); #1;

        // conflicting repeat of minterm 2
        do_start();
        push("conflict", 0, 1, 0, 8'hFF, 16'hC837, 16'h0000, 8'd9);
        send(2, 1'b1, 1'b0);
        send(2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) if (i != 2) send(i, fm[i], f1m[i]);
        repeat (3) @(posedge clk); #1;

        // start wins over a same-cycle sample
        start = 1'b1; in_valid = 1'b1; in_vec = 3'd0; out_vec = 2'b01;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        chk("prio_seen", seen_mask, 0);
        chk("prio_cnt", sample_cnt, 0);
        chk("prio_done", done, 0);
        chk("prio_ready", in_ready, 1);

        // reset mid-run
        for (int i = 0; i < 4; i++) send(i, fm[i], f1m[i]);
        chk("mid_cnt", sample_cnt, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_seen", seen_mask, 0);
        chk("abort_obs", obs_mask, 0);
        chk("abort_err", err_mask, 0);
        chk("abort_cnt", sample_cnt, 0);
        chk("abort_ready", in_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_start();
        push("after_reset", 1, 0, 0, 8'hFF, 16'hC837, 16'h0000, 8'd8);
        sweep(fm, f1m);
        repeat (3) @(posedge clk); #1;

`ifdef TT_TIMEOUT_EN
        do_start();
        push("timeout", 0, 0, 1, 8'h1F, 16'h0817, 16'h0000, 8'd5);
        for (int i = 0; i < 5; i++) send(i, fm[i], f1m[i]);
`endif

        for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("scoreboard_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
